button_conditioner: RTL
=======================

Name: button_conditioner

Overview:
- Front-end conditioning stage for the five push-buttons (Barriba, Babajo, Bderecha, Bizquierda, Bcentro) before the menu/control FSM.
- Per button: synchronises the raw pad input, debounces it, and emits a clean level plus a one-cycle press pulse.
- Selected buttons (default up/down) auto-repeat while held, so time/date fields scroll when a key is held.
- The control FSM consumes only btn_pulse/btn_level, never raw pads.

Parameters:
- N_BTN, 5, number of buttons; bit order 0=arriba, 1=abajo, 2=derecha, 3=izquierda, 4=centro.
- DEBOUNCE_CYCLES, 1000000, consecutive cycles of a changed synchronised value before level updates (10 ms at 100 MHz); must be >=2.
- REPEAT_DELAY, 50000000, cycles from press pulse to first repeat pulse; must be >=2.
- REPEAT_RATE, 10000000, cycles between subsequent repeat pulses; must be >=2.
- REPEAT_MASK, 5'b00011, per-button auto-repeat enable.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous, active-high reset.
- btn_raw  in  N_BTN  asynchronous pad inputs, active-high.
- btn_level  out  N_BTN  debounced level, registered.
- btn_pulse  out  N_BTN  one-cycle press/repeat strobe, registered.
- any_pulse  out  1  OR of btn_pulse, registered in the same cycle as btn_pulse.

Behaviour:
- Interface: one clock CLK. RST is synchronous, active-high, sampled on the CLK rising edge.
- Reset: all synchroniser flops, debounce counters, repeat counters, btn_level, btn_pulse and any_pulse are 0; every FSM is in IDLE. Reset overrides all other activity, including an operation in progress.
- Synchroniser: two flops per bit; s = second flop.
- Debounce, per bit:
  - dcnt clears whenever s == btn_level; otherwise it increments.
  - When dcnt reaches DEBOUNCE_CYCLES-1 and s still differs, btn_level takes s on that edge and dcnt clears.
  - A raw change held clean shows on btn_level DEBOUNCE_CYCLES+2 edges later.
  - Any bounce back to the current level restarts the count.
- Counter widths are $clog2(max+1) and must never wrap.
- Per-button FSM, three states:
  - IDLE: on the edge where btn_level rises, btn_pulse is 1 in the same cycle as btn_level first reads 1. If REPEAT_MASK[i] is set, go to WAIT and clear rcnt; otherwise go to HELD.
  - HELD: no further pulses; go to IDLE when btn_level falls.
  - WAIT: rcnt increments each cycle. When rcnt reaches REPEAT_DELAY-1, pulse, clear rcnt and go to REPEAT. First repeat pulse comes exactly REPEAT_DELAY cycles after the press pulse.
  - REPEAT: rcnt increments. When rcnt reaches REPEAT_RATE-1, pulse and clear rcnt. Pulses are spaced exactly REPEAT_RATE cycles apart.
  - From WAIT or REPEAT: btn_level falling forces IDLE, clears rcnt, and produces no pulse in that cycle.
- Release generates no pulse. btn_pulse is never high for two consecutive cycles on the same bit.
- Buttons are fully independent: simultaneous presses pulse in the same cycle, with no priority or masking.
- Reset mid-hold: outputs are 0 the cycle after RST. If the button is still held after RST deasserts, it is treated as a new press: btn_level/btn_pulse rise DEBOUNCE_CYCLES+2 edges after RST release.
- A button held at power-up (after reset) yields exactly one press pulse, plus repeats if masked.

Test Plan (sim params DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=5):
- Clean press of bit4 (centro), raw high at edge t, held 30 cycles -> btn_level[4] high from edge t+6; btn_pulse[4]=1 for exactly one cycle at t+6; any_pulse matches; no repeats; level falls 6 edges after raw release; no release pulse.
- Chatter on bit2: raw toggles every 2 cycles for 10 cycles, then holds high -> exactly one btn_pulse[2], 6 edges after the final rising raw edge; btn_level never glitches during chatter.
- Hold bit0 (arriba) raw high for 60 cycles -> pulses at P, P+20, P+25, P+30, ... while level is high (P = press pulse cycle); pulse count matches 1+1+floor((level_high_cycles-21)/5); no pulse after level falls.
- Release bit1 during REPEAT, press again 10 cycles later -> new press pulse; first repeat again 20 cycles after it, not 5.
- Bits 0 and 3 raw rise on the same edge -> btn_pulse = 5'b01001 in one cycle; any_pulse = 1 for that one cycle.
- RST asserted for 2 cycles while bit4 is held with level=1 -> all outputs 0 on the edge after RST; after RST deasserts with raw still high, btn_level[4] and one btn_pulse[4] appear 6 edges later.

Source files
------------

// File: rtl/button_conditioner.sv
// Push-button front end: per-button two-flop synchroniser, debounce filter,
// press pulse and optional hold-to-repeat strobes for the menu/control FSM.
module button_conditioner #(
    parameter int               N_BTN           = 5,
    parameter int               DEBOUNCE_CYCLES = 1000000,
    parameter int               REPEAT_DELAY    = 50000000,
    parameter int               REPEAT_RATE     = 10000000,
    parameter logic [N_BTN-1:0] REPEAT_MASK     = 5'b00011
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pulse,
    output logic             any_pulse
);

    localparam int R_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int DW    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RW    = (R_MAX > 1) ? $clog2(R_MAX) : 1;

    localparam logic [DW-1:0] D_LAST     = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0] D_ONE      = DW'(1);
    localparam logic [RW-1:0] R_DLY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] R_RPT_LAST = RW'(REPEAT_RATE - 1);
    localparam logic [RW-1:0] R_ONE      = RW'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HELD   = 2'd1,
        ST_WAIT   = 2'd2,
        ST_REPEAT = 2'd3
    } state_t;

    logic [N_BTN-1:0] pulse_next_vec_s;
    logic             any_r;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        logic [1:0]    sync_r;
        logic [DW-1:0] dcnt_r;
        logic [DW-1:0] dcnt_next_s;
        logic          lvl_r;
        logic          lvl_next_s;
        logic          rise_s;
        logic          fall_s;
        state_t        state_r;
        state_t        state_next_s;
        logic [RW-1:0] rcnt_r;
        logic [RW-1:0] rcnt_next_s;
        logic          pulse_r;
        logic          pulse_next_s;

        // Debounce: level follows the synchronised input only after it has differed for DEBOUNCE_CYCLES edges.
        always_comb begin
            dcnt_next_s = '0;
            lvl_next_s  = lvl_r;
            if (sync_r[1] == lvl_r) begin
                dcnt_next_s = '0;
            end else if (dcnt_r == D_LAST) begin
                lvl_next_s  = sync_r[1];
                dcnt_next_s = '0;
            end else begin
                dcnt_next_s = dcnt_r + D_ONE;
            end
        end

        assign rise_s = lvl_next_s & ~lvl_r;
        assign fall_s = ~lvl_next_s & lvl_r;

        // Press/repeat FSM: pulses are timed off the debounced edge so they line up with the new level.
        always_comb begin
            state_next_s = state_r;
            rcnt_next_s  = rcnt_r;
            pulse_next_s = 1'b0;
            case (state_r)
                ST_IDLE: begin
                    rcnt_next_s = '0;
                    if (rise_s) begin
                        pulse_next_s = 1'b1;
                        state_next_s = REPEAT_MASK[i] ? ST_WAIT : ST_HELD;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_HELD: begin
                    rcnt_next_s = '0;
                    if (fall_s) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_HELD;
                    end
                end
                ST_WAIT: begin
                    if (fall_s) begin
                        state_next_s = ST_IDLE;
                        rcnt_next_s  = '0;
                    end else if (rcnt_r == R_DLY_LAST) begin
                        pulse_next_s = 1'b1;
                        rcnt_next_s  = '0;
                        state_next_s = ST_REPEAT;
                    end else begin
                        rcnt_next_s  = rcnt_r + R_ONE;
                    end
                end
                ST_REPEAT: begin
                    if (fall_s) begin
                        state_next_s = ST_IDLE;
                        rcnt_next_s  = '0;
                    end else if (rcnt_r == R_RPT_LAST) begin
                        pulse_next_s = 1'b1;
                        rcnt_next_s  = '0;
                    end else begin
                        rcnt_next_s  = rcnt_r + R_ONE;
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                    rcnt_next_s  = '0;
                end
            endcase
        end

        // Per-button state registers with synchronous reset.
        always_ff @(posedge CLK) begin
            if (RST) begin
                sync_r  <= 2'b00;
                dcnt_r  <= '0;
                lvl_r   <= 1'b0;
                state_r <= ST_IDLE;
                rcnt_r  <= '0;
                pulse_r <= 1'b0;
            end else begin
                sync_r  <= {sync_r[0], btn_raw[i]};
                dcnt_r  <= dcnt_next_s;
                lvl_r   <= lvl_next_s;
                state_r <= state_next_s;
                rcnt_r  <= rcnt_next_s;
                pulse_r <= pulse_next_s;
            end
        end

        assign pulse_next_vec_s[i] = pulse_next_s;
        assign btn_level[i]        = lvl_r;
        assign btn_pulse[i]        = pulse_r;
    end

    // Summary strobe registered from the same next-state terms as btn_pulse.
    always_ff @(posedge CLK) begin
        if (RST) begin
            any_r <= 1'b0;
        end else begin
            any_r <= |pulse_next_vec_s;
        end
    end

    assign any_pulse = any_r;

endmodule
